// File: rtl/tdm_pkg.sv
// Shared TDM definitions for the lane mux (tx) and demux (rx).
// Optional parity is enabled with the TDM_PARITY_EN macro.
package tdm_pkg;

  typedef enum logic {
    StHunt = 1'b0,
    StRecv = 1'b1
  } tdm_state_e;

  localparam int unsigned DefaultLanes = 2;
  localparam int unsigned DefaultWidth = 8;

  function automatic int unsigned frame_bits(int unsigned lanes, int unsigned width);
    return lanes * width;
  endfunction

endpackage

// File: rtl/tdm_shift_cnt.sv
// Serial shift register, beat counter and running parity for the TDM receiver.
// Parity tracking exists only when TDM_PARITY_EN is defined.
module tdm_shift_cnt
  import tdm_pkg::*;
#(
  parameter int unsigned ShW  = 15,
  parameter int unsigned CntW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_bit,
  input  logic            start,
  input  logic            shift,
  input  logic            clear,
  output logic [ShW-1:0]  shreg,
  output logic [CntW-1:0] cnt
`ifdef TDM_PARITY_EN
  ,
  output logic            par
`endif
);

  logic [ShW-1:0]  sh_d, sh_q;
  logic [CntW-1:0] cnt_d, cnt_q;
`ifdef TDM_PARITY_EN
  logic            par_d, par_q;
`endif

  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
`ifdef TDM_PARITY_EN
    par_d = par_q;
`endif
    if (start) begin
      sh_d  = ShW'(in_bit);
      cnt_d = CntW'(1);
`ifdef TDM_PARITY_EN
      par_d = in_bit;
`endif
    end else if (shift) begin
      sh_d  = (sh_q << 1) | ShW'(in_bit);
      cnt_d = cnt_q + CntW'(1);
`ifdef TDM_PARITY_EN
      par_d = par_q ^ in_bit;
`endif
    end else if (clear) begin
      cnt_d = '0;
`ifdef TDM_PARITY_EN
      par_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q  <= '0;
      cnt_q <= '0;
`ifdef TDM_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
`ifdef TDM_PARITY_EN
      par_q <= par_d;
`endif
    end
  end

  assign shreg = sh_q;
  assign cnt   = cnt_q;
`ifdef TDM_PARITY_EN
  assign par   = par_q;
`endif

endmodule

// File: rtl/tdm_demux_rx.sv
// TDM receiver: recovers per-lane words from a sync-framed serial stream.
// Define TDM_PARITY_EN to append and check an even-parity bit per frame.
module tdm_demux_rx
  import tdm_pkg::*;
#(
  parameter int unsigned LANES = DefaultLanes,
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_bit,
  input  logic                   in_sync,
  input  logic                   in_valid,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic                   out_valid,
  output logic                   locked,
  output logic                   sync_err,
  output logic                   par_err
);

  localparam int unsigned FrameBits = frame_bits(LANES, WIDTH);
`ifdef TDM_PARITY_EN
  localparam int unsigned FrameLen  = FrameBits + 1;
  localparam int unsigned ShW       = FrameBits;
`else
  localparam int unsigned FrameLen  = FrameBits;
  // The final data bit is taken straight from in_bit, so one stage is enough to spare.
  localparam int unsigned ShW       = FrameBits - 1;
`endif
  localparam int unsigned CntW      = $clog2(FrameBits + 2);

  tdm_state_e           state_q;
  logic [ShW-1:0]       shreg;
  logic [CntW-1:0]      cnt;
  logic [FrameBits-1:0] frame_word, frame_ord;
  logic                 recv, last_beat, start, shift, clear;

  assign recv      = (state_q == StRecv);
  assign last_beat = (cnt == CntW'(FrameLen - 1));
  assign start     = in_valid & in_sync;
  assign shift     = in_valid & ~in_sync & recv & ~last_beat;
  assign clear     = in_valid & ~in_sync & recv & last_beat;

`ifdef TDM_PARITY_EN
  logic par, par_ok;

  tdm_shift_cnt #(
    .ShW  (ShW),
    .CntW (CntW)
  ) u_shift_cnt (
    .clk    (clk),
    .rst    (rst),
    .in_bit (in_bit),
    .start  (start),
    .shift  (shift),
    .clear  (clear),
    .shreg  (shreg),
    .cnt    (cnt),
    .par    (par)
  );

  assign frame_word = shreg;
  assign par_ok     = ~(par ^ in_bit);
`else
  tdm_shift_cnt #(
    .ShW  (ShW),
    .CntW (CntW)
  ) u_shift_cnt (
    .clk    (clk),
    .rst    (rst),
    .in_bit (in_bit),
    .start  (start),
    .shift  (shift),
    .clear  (clear),
    .shreg  (shreg),
    .cnt    (cnt)
  );

  assign frame_word = {shreg, in_bit};
  assign par_err    = 1'b0;
`endif

  // Lane 0 arrives first, so it sits at the top of the shift order.
  always_comb begin
    frame_ord = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      frame_ord[k*WIDTH +: WIDTH] = frame_word[(LANES-1-k)*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StHunt;
      out_data  <= '0;
      out_valid <= 1'b0;
      sync_err  <= 1'b0;
`ifdef TDM_PARITY_EN
      par_err   <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;
      sync_err  <= 1'b0;
`ifdef TDM_PARITY_EN
      par_err   <= 1'b0;
`endif
      if (in_valid) begin
        unique case (state_q)
          StHunt: begin
            if (in_sync) state_q <= StRecv;
          end
          StRecv: begin
            if (in_sync) begin
              sync_err <= 1'b1;
            end else if (last_beat) begin
              state_q <= StHunt;
`ifdef TDM_PARITY_EN
              if (par_ok) begin
                out_valid <= 1'b1;
                out_data  <= frame_ord;
              end else begin
                par_err <= 1'b1;
              end
`else
              out_valid <= 1'b1;
              out_data  <= frame_ord;
`endif
            end
          end
          default: state_q <= StHunt;
        endcase
      end
    end
  end

  assign locked = recv;

endmodule

// File: tb/tb_tdm_demux_rx.sv
// Self-checking bench for tdm_demux_rx (default build or with TDM_PARITY_EN).
module tb_tdm_demux_rx;

  localparam int unsigned LANES = 2;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned FB    = LANES * WIDTH;
`ifdef TDM_PARITY_EN
  localparam int unsigned FrameLen = FB + 1;
`else
  localparam int unsigned FrameLen = FB;
`endif

  logic          clk = 1'b0;
  logic          rst, in_bit, in_sync, in_valid;
  logic [FB-1:0] out_data;
  logic          out_valid, locked, sync_err, par_err;

  always #5 clk = ~clk;

  tdm_demux_rx #(
    .LANES (LANES),
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_bit    (in_bit),
    .in_sync   (in_sync),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .locked    (locked),
    .sync_err  (sync_err),
    .par_err   (par_err)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc_n = 0;
  int valid_at[$];

  // Reference model: bits collected since the last sync.
  bit            mq[$];
  bit            in_frame;
  logic [FB-1:0] e_data;
  bit            e_valid, e_serr, e_perr;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  task automatic model_step(bit r, bit v, bit b, bit s);
    logic [FB-1:0] w;
    bit            p;
    e_valid = 1'b0;
    e_serr  = 1'b0;
    e_perr  = 1'b0;
    if (r) begin
      in_frame = 1'b0;
      mq.delete();
      e_data = '0;
    end else if (v) begin
      if (s) begin
        if (in_frame) e_serr = 1'b1;
        mq.delete();
        mq.push_back(b);
        in_frame = 1'b1;
      end else if (in_frame) begin
        mq.push_back(b);
        if (mq.size() == FrameLen) begin
          in_frame = 1'b0;
          w = '0;
          p = 1'b0;
          for (int i = 0; i < int'(FB); i++) begin
            w[(i / WIDTH) * WIDTH + (WIDTH - 1 - (i % WIDTH))] = mq[i];
          end
          foreach (mq[i]) p ^= mq[i];
`ifdef TDM_PARITY_EN
          if (p) begin
            e_perr = 1'b1;
          end else begin
            e_valid = 1'b1;
            e_data  = w;
          end
`else
          e_valid = 1'b1;
          e_data  = w;
`endif
        end
      end
    end
  endtask

  task automatic cyc(bit r, bit v, bit b, bit s);
    rst      = r;
    in_valid = v;
    in_bit   = b;
    in_sync  = s;
    @(posedge clk);
    model_step(r, v, b, s);
    cyc_n++;
    #1;
    chk("out_valid", 64'(out_valid), 64'(e_valid));
    chk("sync_err",  64'(sync_err),  64'(e_serr));
    chk("par_err",   64'(par_err),   64'(e_perr));
    chk("locked",    64'(locked),    64'(in_frame));
    chk("out_data",  64'(out_data),  64'(e_data));
    if (out_valid === 1'b1) valid_at.push_back(cyc_n);
  endtask

  task automatic send_frame(logic [FB-1:0] w, int gap_max, bit gap_sync, bit flip);
    bit b;
    for (int i = 0; i < int'(FB); i++) begin
      b = w[(i / WIDTH) * WIDTH + (WIDTH - 1 - (i % WIDTH))];
      cyc(1'b0, 1'b1, b, i == 0);
      if (gap_max > 0 && i < int'(FB) - 1) begin
        repeat ($urandom_range(gap_max, 1)) cyc(1'b0, 1'b0, 1'($urandom), gap_sync);
      end
    end
`ifdef TDM_PARITY_EN
    cyc(1'b0, 1'b1, (^w) ^ flip, 1'b0);
`else
    if (flip) b = 1'b0;
`endif
  endtask

  task automatic send_partial(int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'($urandom), i == 0);
  endtask

  initial begin
    int spacing;
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; in_sync = 1'b0;

    // Reset with random inputs, then unsynchronised bits must be discarded.
    repeat (3) cyc(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
    chk("reset_data", 64'(out_data), 64'h0);
    repeat (20) cyc(1'b0, 1'b1, 1'($urandom), 1'b0);
    chk("hunt_no_valid", 64'(valid_at.size()), 64'd0);

    // Nominal frame.
    send_frame(16'h3CA5, 0, 1'b0, 1'b0);
    chk("nominal_data", 64'(out_data), 64'h3CA5);
    chk("nominal_count", 64'(valid_at.size()), 64'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // Gaps with in_sync high while in_valid is low.
    send_frame(16'h1234, 0, 1'b0, 1'b0);
    send_frame(16'h3CA5, 3, 1'b1, 1'b0);
    chk("gap_data", 64'(out_data), 64'h3CA5);

    // Mid-frame sync on beat 6, then a clean frame starting at that beat.
    send_partial(5);
    send_frame(16'h00FF, 0, 1'b0, 1'b0);
    chk("midsync_data", 64'(out_data), 64'h00FF);

    // Sync landing on the final beat of a frame.
    send_partial(int'(FrameLen) - 1);
    send_frame(16'hBEEF, 0, 1'b0, 1'b0);
    chk("lastbeat_sync_data", 64'(out_data), 64'hBEEF);

    // Back-to-back frames, then reset in the middle of a third.
    valid_at.delete();
    send_frame(16'(($urandom)), 0, 1'b0, 1'b0);
    send_frame(16'(($urandom)), 0, 1'b0, 1'b0);
    send_partial(8);
    cyc(1'b1, 1'b1, 1'($urandom), 1'($urandom));
    chk("b2b_count", 64'(valid_at.size()), 64'd2);
    spacing = (valid_at.size() >= 2) ? valid_at[1] - valid_at[0] : -1;
    chk("b2b_spacing", 64'(spacing), 64'(FrameLen));
    chk("rst_locked", 64'(locked), 64'h0);
    chk("rst_data", 64'(out_data), 64'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

`ifdef TDM_PARITY_EN
    send_frame(16'h3CA5, 0, 1'b0, 1'b0);
    chk("par_good_data", 64'(out_data), 64'h3CA5);
    send_frame(16'h1234, 0, 1'b0, 1'b1);
    chk("par_bad_kept", 64'(out_data), 64'h3CA5);
    send_frame(16'h1234, 0, 1'b0, 1'b0);
    send_frame(16'h3CA5, 0, 1'b0, 1'b1);
    chk("par_bad_kept2", 64'(out_data), 64'h1234);
`endif

    // Randomised traffic with aborts, gaps and parity flips.
    repeat (12) begin
      if ($urandom_range(2, 0) == 0) send_partial(int'($urandom_range(FrameLen - 1, 1)));
      send_frame(16'($urandom), int'($urandom_range(2, 0)), 1'($urandom),
                 $urandom_range(3, 0) == 0);
      repeat ($urandom_range(2, 0)) cyc(1'b0, 1'b0, 1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tdm_demux_rx.md
# tdm_demux_rx

Receive-side counterpart of the team's select-driven lane multiplexer. Takes a time-division-multiplexed serial stream, each frame marked by a sync strobe, and recovers the parallel per-lane words the transmit-side mux interleaved. Sits between the serial input pins and the user logic that consumes lane data. Framing errors are flagged and followed by automatic resynchronisation.

## Interface
- LANES, 2: number of multiplexed lanes per frame (≥2)
- WIDTH, 8: bits per lane word (≥1)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset; active-high
- in_bit  in  1  serial data bit
- in_sync  in  1  frame marker; high with the first bit of a frame
- in_valid  in  1  qualifies in_bit/in_sync this cycle
- out_data  out  LANES*WIDTH  recovered frame; lane k at [k*WIDTH +: WIDTH]
- out_valid  out  1  one-cycle pulse: out_data updated
- locked  out  1  high while a frame is being received
- sync_err  out  1  one-cycle pulse: sync seen mid-frame
- par_err  out  1  one-cycle pulse: parity failure (0 when parity is compiled out)

## Operation
- FRAME_BITS = LANES*WIDTH. Frame order: lane 0 first, each lane MSB first.
- Only cycles with in_valid=1 are beats. Non-beat cycles change nothing, and in_sync is ignored on them.
- HUNT (reset state): beats without sync are discarded. A beat with sync captures bit 0, sets cnt=1 and moves to RECV.
- RECV: each beat shifts in_bit into a FRAME_BITS shift register and increments cnt.
  - When cnt reaches the frame length (FRAME_BITS, or FRAME_BITS+1 with parity), the frame is complete. Transfer shift register → out_data, pulse out_valid, return to HUNT.
  - A beat with sync while cnt is 1..last-1 aborts the partial frame and pulses sync_err. That beat becomes bit 0 of a new frame (cnt=1, stay in RECV).
  - A sync on the final beat of a frame is a mid-frame sync: the abort rule applies, and no out_valid is produced.
- Back-to-back frames: a sync beat in the cycle directly after completion starts the next frame with no gap.
- out_data holds its last value until the next good frame. It is never partially updated.
- locked = (state == RECV).
- Counter width is $clog2(FRAME_BITS+2).
- Reset at any time, including mid-frame: state HUNT, cnt 0, shift register 0.

## Timing
- Reset values: out_data 0, out_valid 0, locked 0, sync_err 0, par_err 0.
- Latency: out_valid and the new out_data appear on the clock edge after the final beat is sampled, so they are visible one cycle after that beat.
- Error pulses follow the same one-cycle latency after the offending beat.
- locked rises in the cycle after the sync beat and falls in the same cycle out_valid rises.
- No backpressure. The consumer must take out_data before the next completion, which comes at least FRAME_BITS beats later.
- All outputs are registered.

## Configuration
- TDM_PARITY_EN defined:
  - Each frame carries one extra bit after the data, chosen so the frame has even parity over data plus parity bit.
  - Frame length is FRAME_BITS+1.
  - On mismatch: par_err pulses in place of out_valid, and out_data is unchanged.
- TDM_PARITY_EN not defined:
  - Frame length is FRAME_BITS.
  - par_err is tied to 0, and no parity logic is present.

## Structure
- Shared package tdm_pkg holds:
  - state enum (HUNT, RECV)
  - default LANES/WIDTH constants, shared with the transmit-side mux
  - FRAME_BITS helper function
- One natural sub-module: tdm_shift_cnt, containing the shift register, beat counter and running parity. The top level holds the FSM and output registers.

## Test plan
- Reset: hold rst 3 cycles with random inputs → all outputs 0, locked 0; bits without sync after reset → no out_valid.
- Nominal (LANES=2, WIDTH=8): sync + 16 beats carrying 0xA5 then 0x3C → out_valid one cycle after beat 16, out_data=16'h3CA5.
- Gaps: same frame with in_valid low for 1–3 random cycles between beats, in_sync high during a gap → identical result, no sync_err.
- Mid-frame sync: sync at beat 6, then 16 clean beats of 0xFF,0x00 → sync_err pulse one cycle after beat 6, then out_data=16'h00FF.
- Back-to-back: two frames with zero gap, plus rst asserted at beat 8 of a third frame → two out_valid pulses exactly 16 cycles apart; after rst, locked=0 and out_data=0.
- TDM_PARITY_EN: frame 0xA5,0x3C with correct parity bit → out_valid; the same frame with the parity bit flipped → par_err pulse, out_data unchanged.
